// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the register-interface slave state type.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } regif_state_t;

  // Timeout counter width: enough to reach the limit, clamped to 8..16 bits.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    if (w < 8) w = 8;
    else if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/ahblite_be_gen.sv
// Byte-enable and alignment-error decode from HSIZE and the low address bits.
module ahblite_be_gen
  import ahblite_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       align_err
);

  always_comb begin
    be        = '0;
    align_err = 1'b0;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        be        = 4'b0011 << addr_lo;
        align_err = addr_lo[0];
      end
      HSIZE_WORD: begin
        be        = '1;
        align_err = |addr_lo;
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahblite_regif_slave.sv
// AHB-Lite slave front end driving a wait-stated local register bus.
// Optional ACCESS-state timeout is enabled by defining AHBLITE_REGIF_TIMEOUT_EN.
module ahblite_regif_slave
  import ahblite_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned NUM_REGS       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        HSEL,
  input  logic [ADDR_W-1:0]           HADDR,
  input  logic [1:0]                  HTRANS,
  input  logic                        HWRITE,
  input  logic [2:0]                  HSIZE,
  input  logic [31:0]                 HWDATA,
  input  logic                        HREADY,
  output logic [31:0]                 HRDATA,
  output logic                        HREADYOUT,
  output logic                        HRESP,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr,
  output logic                        reg_rd,
  output logic                        reg_wr,
  output logic [3:0]                  reg_be,
  output logic [31:0]                 reg_wdata,
  input  logic [31:0]                 reg_rdata,
  input  logic                        reg_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
      64'(NUM_REGS) * 64'd4 > (64'd1 << ADDR_W)) begin : g_param_check
    $error("ahblite_regif_slave: illegal parameter combination");
  end

  regif_state_t state, state_nx;
  logic [3:0]   be;
  logic         align_err;
  logic         accept;
  logic         bad;
  logic         start;
  logic         timeout_hit;

  ahblite_be_gen u_be_gen (
    .size      (HSIZE),
    .addr_lo   (HADDR[1:0]),
    .be        (be),
    .align_err (align_err)
  );

  assign accept    = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign bad       = align_err || (32'(HADDR[ADDR_W-1:2]) >= NUM_REGS);
  assign start     = (state_nx == ST_ACCESS) && (state != ST_ACCESS);
  assign reg_wdata = HWDATA;

`ifdef AHBLITE_REGIF_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  // Count holds the number of ACCESS cycles already elapsed, so the hit
  // fires in the TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout_hit = (state == ST_ACCESS) && (32'(to_cnt) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge HCLK) begin
    if (HRESET || state != ST_ACCESS) to_cnt <= '0;
    else                              to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) state_nx = bad ? ST_ERR1 : ST_ACCESS;
        else        state_nx = ST_IDLE;
      end
      ST_ACCESS: begin
        if (reg_ready)        state_nx = ST_DONE;
        else if (timeout_hit) state_nx = ST_ERR1;
      end
      ST_ERR1: state_nx = ST_ERR2;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus-facing outputs are flops loaded from the next state, not state decodes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_be    <= '0;
    end else begin
      state     <= state_nx;
      HREADYOUT <= !(state_nx == ST_ACCESS || state_nx == ST_ERR1);
      HRESP     <= (state_nx == ST_ERR1 || state_nx == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      if (start) begin
        reg_addr <= HADDR[IDX_W+1:2];
        reg_be   <= be;
        reg_rd   <= !HWRITE;
        reg_wr   <= HWRITE;
      end else if (state_nx != ST_ACCESS) begin
        reg_rd <= 1'b0;
        reg_wr <= 1'b0;
      end
      if (state == ST_ACCESS && reg_rd && reg_ready) HRDATA <= reg_rdata;
    end
  end

endmodule

// File: doc/ahblite_regif_slave.md
Name: ahblite_regif_slave

Overview:
- AHB-Lite slave (responder) front end, sitting on one HSEL output of the AHB-Lite address decoder.
- Captures the address phase, checks alignment and range, and drives a simple local register bus with wait-state handshake.
- Returns HRDATA/HREADYOUT/HRESP, including the two-cycle ERROR response.
- Used by peripheral blocks (filter-wheel motor/encoder registers) behind the AHB-Lite bus matrix.

Parameters:
- ADDR_W, 12, number of HADDR low bits decoded locally (slot size 2**ADDR_W bytes).
- NUM_REGS, 64, number of 32-bit registers implemented; word index >= NUM_REGS is out of range.
- TIMEOUT_CYCLES, 255, ACCESS-state cycle limit before ERROR (used only with the optional feature).

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  ADDR_W  byte address, low bits.
- HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWDATA  in  32  write data; valid in the data phase.
- HREADY  in  1  bus-level ready.
- HRDATA  out  32  read data, registered.
- HREADYOUT  out  1  slave ready, registered.
- HRESP  out  1  0=OKAY, 1=ERROR, registered.
- reg_addr  out  $clog2(NUM_REGS)  word index.
- reg_rd  out  1  read strobe, level.
- reg_wr  out  1  write strobe, level.
- reg_be  out  4  byte enables, little-endian.
- reg_wdata  out  32  equals HWDATA.
- reg_rdata  in  32  read data; valid when reg_ready=1.
- reg_ready  in  1  register-side completion.

Behaviour:
- Reset (HRESET=1 at a clock edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, reg_rd=reg_wr=0, reg_addr=0, reg_be=0.
  - Reset mid-transfer abandons the transfer; strobes are low from the next cycle.
- Accept: a transfer is accepted when HSEL & HREADY & HTRANS[1] all hold at a clock edge. HADDR, HWRITE and HSIZE are latched on that edge.
  - IDLE and BUSY transfers, and cycles with HSEL=0, get a zero-wait OKAY: HREADYOUT=1, HRESP=0.
- Error check on accept:
  - HSIZE>2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]!=0;
  - HADDR[ADDR_W-1:2] >= NUM_REGS.
  - Any of these sends the transfer to ERR1; no strobe is issued.
- States: IDLE, ACCESS, DONE, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. On a legal accept -> ACCESS; on an illegal accept -> ERR1.
- ACCESS:
  - Outputs: HREADYOUT=0; reg_rd=!write or reg_wr=write, held high; reg_addr and reg_be from the latched values.
  - On the first edge with reg_ready=1: HRDATA<=reg_rdata (reads only; writes leave HRDATA unchanged), strobes drop, next state DONE.
  - Minimum latency from address-phase edge to data completion is 2 cycles (1 wait state).
- DONE: HREADYOUT=1, HRESP=0. A new accept in this cycle goes to ACCESS or ERR1 (back-to-back transfers); otherwise -> IDLE.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1. A new accept in this cycle is honoured (goes to ACCESS or ERR1); otherwise -> IDLE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0];
  - half: 4'b0011 << addr[1:0];
  - word: 4'b1111.
- HRDATA holds its last value outside DONE.
- reg_ready is ignored outside ACCESS.

Optional Feature:
- Macro: AHBLITE_REGIF_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If the count reaches TIMEOUT_CYCLES with reg_ready still 0, strobes drop and the state goes to ERR1.
  - reg_ready arriving in that same cycle takes priority (normal completion).
- When undefined: ACCESS waits indefinitely and there is no counter logic.

Decomposition:
- Package ahblite_pkg holds:
  - HTRANS codes (HTRANS_IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE codes;
  - HRESP_OKAY/HRESP_ERROR;
  - the state enum regif_state_t.
- One sub-module, ahblite_be_gen: combinational; takes HSIZE and HADDR[1:0]; outputs the 4-bit byte enable and an align_err flag. It is reused by the other AHB slaves.

Test Plan:
- Word write, 0x004 <= 0xDEADBEEF, reg_ready tied 1 -> reg_wr high for 1 cycle with reg_addr=1, reg_be=1111, reg_wdata=0xDEADBEEF; HREADYOUT low for 1 cycle; HRESP=0.
- Word read at 0x008, reg_ready delayed 3 cycles, reg_rdata=0x12345678 -> HREADYOUT low 4 cycles, then high with HRDATA=0x12345678.
- Byte write at 0x00B -> reg_be=1000; half write at 0x002 -> reg_be=1100.
- Unaligned word at 0x006, and out-of-range index 64 -> no strobe; HRESP=1 with HREADYOUT 0 then 1; a following legal NONSEQ presented in ERR2 completes OKAY.
- Back-to-back NONSEQ reads to 0x000 and 0x004 -> second accepted in DONE; two HRDATA beats in order; HRESET asserted during ACCESS -> strobes low next cycle, HREADYOUT=1.
- With AHBLITE_REGIF_TIMEOUT_EN and TIMEOUT_CYCLES=4, reg_ready held 0 -> ERR1 after 4 ACCESS cycles, HRESP=1 for two cycles.
